mole_spawner: RTL



---
 rtl/mole_spawner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mole_spawner.sv
// mole_spawner: picks pseudo-random hole positions from a free-running
// 16-bit Galois LFSR, shows one mole at a time and retires it on a hit or
// a timeout. It counts spawned moles and unhit (timed-out) moles.
// Optional feature macro: SPEEDUP_EN. When it is defined, the UP window
// shrinks by UP_TICKS/16 after each hit, with a floor of UP_TICKS/4.
module mole_spawner #(
    parameter int          NUM_HOLES = 18,
    parameter int          UP_TICKS  = 50000000,
    parameter int          GAP_TICKS = 12500000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 hit,
    output logic [4:0]           mole_position,
    output logic                 mole_valid,
    output logic [NUM_HOLES-1:0] mole_leds,
    output logic [11:0]          mole_count,
    output logic [11:0]          miss_count
);

    localparam logic [4:0]  NO_MOLE   = 5'd31;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [11:0] CNT_MAX   = 12'hFFF;
    localparam int          TMAX      = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int          TW        = $clog2(TMAX + 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] UP_FULL  = TW'(UP_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_PICK, S_UP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [4:0]             pos_q, pos_d;
    logic                   valid_q, valid_d;
    logic [NUM_HOLES-1:0]   leds_q, leds_d;
    logic [4:0]             last_q, last_d;
    logic [11:0]            mcnt_q, mcnt_d;
    logic [11:0]            miss_q, miss_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [4:0]             cand;
    logic [TW-1:0]          up_last;

`ifdef SPEEDUP_EN
    localparam logic [TW-1:0] WIN_STEP  = TW'(UP_TICKS / 16);
    localparam logic [TW-1:0] WIN_FLOOR = TW'(UP_TICKS / 4);
    logic [TW-1:0] window_q, window_d;

    // Current UP length comes from the shrinking window.
    always_comb up_last = window_q - TW'(1);
`else
    // Fixed UP length.
    always_comb up_last = UP_FULL - TW'(1);
`endif

    assign cand = lfsr_q[4:0];

    // Next-state logic for the FSM, the counters, the LFSR and the outputs.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        leds_d  = leds_q;
        last_d  = last_q;
        mcnt_d  = mcnt_q;
        miss_d  = miss_q;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
`ifdef SPEEDUP_EN
        window_d = window_q;
`endif
        if (!run) begin
            // Abandoning the game: blank the display. A mole that was up
            // counts as neither a hit nor a miss.
            state_d = S_IDLE;
            timer_d = '0;
            pos_d   = NO_MOLE;
            valid_d = 1'b0;
            leds_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_GAP;
                    timer_d = '0;
`ifdef SPEEDUP_EN
                    window_d = UP_FULL;
`endif
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_d = S_PICK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_PICK: begin
                    // Reject an out-of-range candidate or a repeat of the
                    // last hole, then retry next cycle with a fresh LFSR value.
                    if ((int'(cand) < NUM_HOLES) && (cand != last_q)) begin
                        state_d = S_UP;
                        timer_d = '0;
                        pos_d   = cand;
                        valid_d = 1'b1;
                        leds_d  = NUM_HOLES'(1) << cand;
                        last_d  = cand;
                        if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + 12'd1;
                    end
                end
                S_UP: begin
                    // A hit takes priority over a timeout in the same cycle.
                    if (hit || (timer_q == up_last)) begin
                        state_d = S_GAP;
                        timer_d = '0;
                        pos_d   = NO_MOLE;
                        valid_d = 1'b0;
                        leds_d  = '0;
                        if (!hit && (miss_q != CNT_MAX)) miss_d = miss_q + 12'd1;
`ifdef SPEEDUP_EN
                        if (hit) begin
                            if (window_q >= WIN_FLOOR + WIN_STEP)
                                window_d = window_q - WIN_STEP;
                            else
                                window_d = WIN_FLOOR;
                        end
`endif
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // All state registers. Reset takes priority over run and hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pos_q   <= NO_MOLE;
            valid_q <= 1'b0;
            leds_q  <= '0;
            last_q  <= NO_MOLE;
            mcnt_q  <= '0;
            miss_q  <= '0;
            lfsr_q  <= LFSR_SEED;
`ifdef SPEEDUP_EN
            window_q <= UP_FULL;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            leds_q  <= leds_d;
            last_q  <= last_d;
            mcnt_q  <= mcnt_d;
            miss_q  <= miss_d;
            lfsr_q  <= lfsr_d;
`ifdef SPEEDUP_EN
            window_q <= window_d;
`endif
        end
    end

    assign mole_position = pos_q;
    assign mole_valid    = valid_q;
    assign mole_leds     = leds_q;
    assign mole_count    = mcnt_q;
    assign miss_count    = miss_q;

endmodule
